memory_arbiter: RTL
===================

# memory_arbiter

Shares the single external memory port between the fetch stage (instruction requester) and the execute stage (data requester: loads and stores). Each requester sees its own valid/ready/error interface; the arbiter queues one request per requester, issues them one at a time, and routes each response back to its owner. Data has priority, with a one-shot anti-starvation rule for fetch. The block sits between the pipeline stages and the memory/bus adapter.

## Interface
- No parameters; address/data width fixed at 32 bits.
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- imem_valid  in  1  fetch request strobe (one-cycle pulse)
- imem_addr  in  32  fetch address
- imem_flush  in  1  discard fetch request pending or in flight
- imem_ready  out  1  fetch response valid
- imem_error  out  1  fetch access fault (valid with imem_ready)
- imem_rdata  out  32  fetch read data
- dmem_valid  in  1  data request strobe (one-cycle pulse)
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte write strobes; 0 = load
- dmem_ready  out  1  data response valid
- dmem_error  out  1  data access fault (valid with dmem_ready)
- dmem_rdata  out  32  load data
- mem_valid  out  1  request to memory (one-cycle pulse)
- mem_instr  out  1  1 = current transaction is a fetch
- mem_addr / mem_wdata / mem_wstrb  out  32/32/4  request fields, held stable until response
- mem_ready  in  1  memory response strobe
- mem_error  in  1  memory access fault
- mem_rdata  in  32  memory read data

## Operation
- Two pending slots (I, D), each holding a valid bit plus captured fields. A requester's valid pulse captures its fields into its slot. Any valid pulse while that requester's slot is pending or in flight is ignored.
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
  - FLUSHED: fetch transaction in flight whose response is discarded.
- Arbitration in IDLE, over slots valid at the clock edge:
  - Only one slot valid: that slot is issued.
  - Both valid: D wins, unless `lost_i` = 1, in which case I wins.
  - `lost_i` is set when I loses a contended arbitration and cleared when I is granted.
- Issue: mem_valid = 1 for exactly one cycle. mem_addr/wdata/wstrb/instr are loaded from the granted slot, the slot is cleared, and the FSM enters BUSY_x.
  - A fetch issue forces mem_wstrb = 0 and mem_wdata = 0.
- Response, on mem_ready = 1 in a BUSY state:
  - BUSY_I: imem_ready = 1, imem_error = mem_error, imem_rdata = mem_rdata.
  - BUSY_D: the same onto the dmem_* outputs.
  - These outputs are combinational from mem_* in the same cycle, gated by state, and 0 otherwise.
  - FSM returns to IDLE.
- mem_ready in IDLE is ignored.
- imem_flush = 1:
  - Clears slot I (also overrides a coincident imem_valid).
  - Turns BUSY_I into FLUSHED. In FLUSHED, mem_ready produces no imem_ready, and the FSM returns to IDLE.
  - Flush has no effect on data traffic.

## Timing
- Reset (reset = 0 at a clock edge):
  - All outputs 0, both slots empty, FSM = IDLE, lost_i = 0.
  - Reset mid-transaction abandons it. A mem_ready arriving after reset is ignored.
- Capture at edge N (valid high in cycle N-1): the slot is valid from cycle N.
- Best case: request pulse in cycle N, mem_valid in cycle N+1 (arbitration is registered).
- Response to requester: same cycle as mem_ready, zero added latency.
- Back-to-back: mem_ready in cycle M, next issue (mem_valid) in cycle M+1, no dead cycle beyond the state return.
- A mem_ready coinciding with a new requester pulse:
  - The response is routed.
  - The pulse is captured.
  - The new request is arbitrated next cycle.
- A requester may pulse valid in the same cycle its own response is delivered. The slot is free at that edge, so the request is accepted.
- At most one transaction is outstanding; mem_valid never fires in a BUSY state.

## Test plan
- Reset, then a single data load (addr 0x100, wstrb 0) → mem_valid one cycle after the pulse with mem_instr = 0; mem_ready after 3 cycles with rdata 0xDEADBEEF → dmem_ready = 1, dmem_rdata = 0xDEADBEEF in the same cycle; imem_ready stays 0.
- Simultaneous imem_valid (0x200) and dmem_valid (0x300) → D issued first. After its response, I issued next cycle (lost_i = 1). Then a repeated contention issues D first again.
- Fetch in flight, imem_flush pulsed → memory response for 0x200 produces no imem_ready. A subsequent fetch (0x204) completes normally.
- Store (wstrb 0xF, wdata 0x12345678) answered with mem_error = 1 → dmem_ready = 1, dmem_error = 1, and mem_wdata/mem_addr stable throughout BUSY_D.
- Duplicate dmem_valid while a data request is in flight (addr 0x400) → ignored; exactly one memory transaction is observed.
- reset asserted during BUSY_D → all outputs 0. A late mem_ready is ignored. A new fetch after reset issues correctly.

Source files
------------

// File: rtl/memory_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// One pending slot per requester; data has priority, with a one-shot anti-starvation turn for fetch.
module memory_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  input  logic        imem_flush,
  output logic        imem_ready,
  output logic        imem_error,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    FLUSHED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        i_pend_q, i_pend_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic        d_pend_q, d_pend_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_wstrb_q, d_wstrb_d;
  logic        lost_i_q, lost_i_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        mem_instr_q, mem_instr_d;

  logic idle, grant_i, grant_d, i_inflight, d_inflight, i_accept, d_accept;

  assign idle    = (state_q == IDLE);
  assign grant_i = idle && i_pend_q && (!d_pend_q || lost_i_q);
  assign grant_d = idle && d_pend_q && !grant_i;

  // A slot frees on the edge that delivers its response, so a pulse in that cycle is accepted.
  assign i_inflight = ((state_q == BUSY_I) || (state_q == FLUSHED)) && !mem_ready;
  assign d_inflight = (state_q == BUSY_D) && !mem_ready;
  assign i_accept   = imem_valid && !imem_flush && !i_pend_q && !i_inflight;
  assign d_accept   = dmem_valid && !d_pend_q && !d_inflight;

  always_comb begin
    state_d     = state_q;
    i_pend_d    = i_pend_q;
    i_addr_d    = i_addr_q;
    d_pend_d    = d_pend_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_wstrb_d   = d_wstrb_q;
    lost_i_d    = lost_i_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_instr_d = mem_instr_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = imem_flush ? FLUSHED : BUSY_I;
          i_pend_d    = 1'b0;
          lost_i_d    = 1'b0;
          mem_addr_d  = i_addr_q;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          mem_instr_d = 1'b1;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          d_pend_d    = 1'b0;
          if (i_pend_q) lost_i_d = 1'b1;
          mem_addr_d  = d_addr_q;
          mem_wdata_d = d_wdata_q;
          mem_wstrb_d = d_wstrb_q;
          mem_instr_d = 1'b0;
        end
      end
      BUSY_I: begin
        if (mem_ready) state_d = IDLE;
        else if (imem_flush) state_d = FLUSHED;
      end
      BUSY_D, FLUSHED: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (imem_flush) begin
      i_pend_d = 1'b0;
    end else if (i_accept) begin
      i_pend_d = 1'b1;
      i_addr_d = imem_addr;
    end

    if (d_accept) begin
      d_pend_d  = 1'b1;
      d_addr_d  = dmem_addr;
      d_wdata_d = dmem_wdata;
      d_wstrb_d = dmem_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_pend_q    <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wstrb_q   <= '0;
      lost_i_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_pend_q    <= i_pend_d;
      i_addr_q    <= i_addr_d;
      d_pend_q    <= d_pend_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wstrb_q   <= d_wstrb_d;
      lost_i_q    <= lost_i_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_instr_q <= mem_instr_d;
    end
  end

  // Request fields show the granted slot during the issue cycle and are held while busy.
  assign mem_valid = grant_i || grant_d;
  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign mem_wstrb = mem_wstrb_d;
  assign mem_instr = mem_instr_d;

  assign imem_ready = (state_q == BUSY_I) && mem_ready;
  assign imem_error = imem_ready && mem_error;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_ready = (state_q == BUSY_D) && mem_ready;
  assign dmem_error = dmem_ready && mem_error;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;

  assign dbg_state_o = state_q;

endmodule
